key_step_decoder: RTL and testbench
===================================

// Module: key_step_decoder
// PURPOSE
//  Converts PS/2 Set-2 scancode bytes from the keyboard receiver into the
//  stepleft/stepright/stepjump controls consumed by the character movement
//  logic. Tracks make/break/extended prefixes and per-key held state.
//  Resolves left+right conflicts and forces a release after a silence timeout.
// PARAMETERS
//  KEY_LEFT     8'h1C     make code for left ('A')
//  KEY_RIGHT    8'h23     make code for right ('D')
//  KEY_JUMP     8'h29     make code for jump (Space)
//  TIMEOUT_CYC  50000000  cycles without any scancode before all keys are released; 0 = never
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-high reset
//  code_valid   in   1   one-cycle strobe: code holds a new received byte
//  code         in   8   received scancode byte
//  stepleft     out  1   level: move left requested
//  stepright    out  1   level: move right requested
//  stepjump     out  1   one-cycle pulse on jump key press
//  keys_held    out  3   raw held flags {jump,right,left}, for debug
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, held flags 0, last_dir=LEFT, timer 0.
//  - FSM advances only on code_valid; code ignored otherwise.
//    IDLE:  E0->EXT; F0->BRK; E1->IDLE (byte dropped); else MAKE(code), stay IDLE.
//    EXT:   F0->EXT_BRK; else MAKE_EXT(code)->IDLE.
//    BRK:   BREAK(code)->IDLE.   EXT_BRK: BREAK_EXT(code)->IDLE.
//    Unmapped codes still consume the state transition; they never change held flags.
//  - MAKE(k): set held[k]; left/right make also sets last_dir=k. Typematic
//    repeats (make while already held) do not change last_dir or pulse.
//  - BREAK(k): clear held[k]. Break of a non-held key: no effect.
//  - Outputs are registered, 1-cycle latency after the code_valid that
//    completes a sequence (e.g. F0,1C: stepleft falls the cycle after 1C).
//  - stepleft  = held_l & (~held_r | last_dir==LEFT);
//    stepright = held_r & (~held_l | last_dir==RIGHT). Never both high.
//  - Releasing the winning direction while the other is held: other
//    direction asserts next cycle.
//  - stepjump: exactly one 1-cycle pulse on 0->1 transition of held_jump;
//    repeated makes while held produce no pulse.
//  - Timer: cleared on every code_valid, increments otherwise, saturates.
//    On reaching TIMEOUT_CYC: clear all held flags, FSM->IDLE, no jump pulse.
//    Width = $clog2(TIMEOUT_CYC+1); TIMEOUT_CYC=0 disables timer entirely.
//  - Reset asserted mid-sequence (e.g. after E0): FSM returns to IDLE
//    immediately; next byte is decoded as unprefixed.
// CONFIGURATION
//  ARROW_KEYS_EN defined: extended makes E0 6B=left, E0 74=right,
//    E0 75=jump also drive the held logic. Each physical key has its own
//    held flag; direction held = letter OR arrow; last_dir updated by either.
//  ARROW_KEYS_EN undefined: all extended codes ignored (prefix still
//    consumed, so E0 6B never acts as a plain 6B); no arrow flags exist.
// TESTING
//  1C -> stepleft=1 next cycle; F0,1C -> stepleft=0 the cycle after 1C.
//  1C,23 -> stepright=1,stepleft=0; F0,23 -> stepleft=1 the next cycle.
//  29,29,29 (typematic) -> exactly one stepjump pulse; F0,29,29 -> 2nd pulse.
//  E0,1C (ARROW_KEYS_EN undef) -> no output change; following 1C -> stepleft=1.
//  ARROW_KEYS_EN: E0,6B -> stepleft=1; 1C then E0,F0,6B -> stepleft stays 1.
//  TIMEOUT_CYC=100: 23, then 100 idle cycles -> stepright=0; rst after E0 -> 1C gives stepleft=1.

Source files
------------

// File: rtl/key_step_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_step_decoder: PS/2 Set-2 scancodes -> stepleft/stepright/stepjump.   |
// | Optional ARROW_KEYS_EN adds E0 6B/74/75 arrow keys.  Rev 1.0             |
// +--------------------------------------------------------------------------+
module key_step_decoder #(
  parameter logic [7:0]  KEY_LEFT    = 8'h1C,
  parameter logic [7:0]  KEY_RIGHT   = 8'h23,
  parameter logic [7:0]  KEY_JUMP    = 8'h29,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       code_valid,
  input  logic [7:0] code,
  output logic       stepleft,
  output logic       stepright,
  output logic       stepjump,
  output logic [2:0] keys_held
);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_ext     = 2'd1;
  localparam logic [1:0] c_st_brk     = 2'd2;
  localparam logic [1:0] c_st_ext_brk = 2'd3;

  localparam logic       c_dir_left   = 1'b0;
  localparam logic       c_dir_right  = 1'b1;

  localparam logic [7:0] c_code_ext   = 8'hE0;
  localparam logic [7:0] c_code_brk   = 8'hF0;
  localparam logic [7:0] c_code_pause = 8'hE1;

  logic [1:0] state_q, state_d;
  logic [2:0] letter_q, letter_d;   // {jump,right,left}
  logic [2:0] letter_hit, letter_new;
  logic [2:0] held_q, held_d;
  logic       last_dir_q, last_dir_d;
  logic       stepleft_q, stepleft_d;
  logic       stepright_q, stepright_d;
  logic       stepjump_q, stepjump_d;
  logic       do_make, do_break, is_ext;
  logic       timeout_fire;

`ifdef ARROW_KEYS_EN
  localparam logic [7:0] c_arrow_left  = 8'h6B;
  localparam logic [7:0] c_arrow_right = 8'h74;
  localparam logic [7:0] c_arrow_jump  = 8'h75;

  logic [2:0] arrow_q, arrow_d;
  logic [2:0] arrow_hit, arrow_new;

  assign arrow_hit = {code == c_arrow_jump, code == c_arrow_right, code == c_arrow_left};
  assign held_q    = letter_q | arrow_q;
  assign held_d    = letter_d | arrow_d;
`else
  assign held_q    = letter_q;
  assign held_d    = letter_d;
`endif

  assign letter_hit = {code == KEY_JUMP, code == KEY_RIGHT, code == KEY_LEFT};

  always_comb begin
    state_d    = state_q;
    letter_d   = letter_q;
    last_dir_d = last_dir_q;
    do_make    = 1'b0;
    do_break   = 1'b0;
    is_ext     = 1'b0;
`ifdef ARROW_KEYS_EN
    arrow_d    = arrow_q;
    arrow_new  = arrow_hit & ~arrow_q;
`endif
    letter_new = letter_hit & ~letter_q;

    if (code_valid) begin
      case (state_q)
        c_st_idle: begin
          if (code == c_code_ext)        state_d = c_st_ext;
          else if (code == c_code_brk)   state_d = c_st_brk;
          else if (code != c_code_pause) do_make = 1'b1;
        end
        c_st_ext: begin
          if (code == c_code_brk) begin
            state_d = c_st_ext_brk;
          end else begin
            do_make = 1'b1;
            is_ext  = 1'b1;
            state_d = c_st_idle;
          end
        end
        c_st_brk: begin
          do_break = 1'b1;
          state_d  = c_st_idle;
        end
        c_st_ext_brk: begin
          do_break = 1'b1;
          is_ext   = 1'b1;
          state_d  = c_st_idle;
        end
        default: state_d = c_st_idle;
      endcase
    end

    // Only a fresh press moves last_dir; typematic repeats leave it alone.
    if (do_make && !is_ext) begin
      letter_d = letter_q | letter_hit;
      if (letter_new[0]) last_dir_d = c_dir_left;
      if (letter_new[1]) last_dir_d = c_dir_right;
    end
    if (do_break && !is_ext) letter_d = letter_q & ~letter_hit;

`ifdef ARROW_KEYS_EN
    if (do_make && is_ext) begin
      arrow_d = arrow_q | arrow_hit;
      if (arrow_new[0]) last_dir_d = c_dir_left;
      if (arrow_new[1]) last_dir_d = c_dir_right;
    end
    if (do_break && is_ext) arrow_d = arrow_q & ~arrow_hit;
`endif

    if (timeout_fire) begin
      state_d  = c_st_idle;
      letter_d = '0;
`ifdef ARROW_KEYS_EN
      arrow_d  = '0;
`endif
    end
  end

  always_comb begin
    stepleft_d  = held_d[0] & (~held_d[1] | (last_dir_d == c_dir_left));
    stepright_d = held_d[1] & (~held_d[0] | (last_dir_d == c_dir_right));
    stepjump_d  = held_d[2] & ~held_q[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= c_st_idle;
      letter_q    <= '0;
      last_dir_q  <= c_dir_left;
      stepleft_q  <= 1'b0;
      stepright_q <= 1'b0;
      stepjump_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      letter_q    <= letter_d;
      last_dir_q  <= last_dir_d;
      stepleft_q  <= stepleft_d;
      stepright_q <= stepright_d;
      stepjump_q  <= stepjump_d;
    end
  end

`ifdef ARROW_KEYS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) arrow_q <= '0;
    else     arrow_q <= arrow_d;
  end
`endif

  generate
    if (TIMEOUT_CYC > 0) begin : g_timer
      localparam int TW = $clog2(TIMEOUT_CYC + 1);
      localparam logic [TW-1:0] c_limit   = TW'(TIMEOUT_CYC);
      localparam logic [TW-1:0] c_fire_at = TW'(TIMEOUT_CYC - 1);

      logic [TW-1:0] timer_q, timer_d;

      always_comb begin
        timer_d = timer_q;
        if (code_valid)              timer_d = '0;
        else if (timer_q != c_limit) timer_d = timer_q + TW'(1);
      end

      // Fires once, on the increment that lands on the limit.
      assign timeout_fire = !code_valid && (timer_q == c_fire_at);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
      end
    end else begin : g_no_timer
      assign timeout_fire = 1'b0;
    end
  endgenerate

  assign stepleft  = stepleft_q;
  assign stepright = stepright_q;
  assign stepjump  = stepjump_q;
  assign keys_held = held_q;

endmodule
`default_nettype wire

// File: tb/tb_key_step_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_key_step_decoder: scoreboard bench for key_step_decoder.  Rev 1.0     |
// +--------------------------------------------------------------------------+
module tb_key_step_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       code_valid;
  logic [7:0] code;
  logic       stepleft, stepright, stepjump;
  logic [2:0] keys_held;

  logic       probe;
  logic       resp_due = 1'b0;
  logic       done = 1'b0;
  int         checks = 0;
  int         failures = 0;

  logic [5:0] exp_q[$];   // {stepleft,stepright,stepjump,keys_held}
  string      tag_q[$];

  key_step_decoder #(.TIMEOUT_CYC(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code       (code),
    .stepleft   (stepleft),
    .stepright  (stepright),
    .stepjump   (stepjump),
    .keys_held  (keys_held)
  );

  always #5 clk = ~clk;

  // Each byte or probe expects a response from the edge that samples it.
  always @(posedge clk) resp_due <= code_valid | probe;

  always @(negedge clk) begin
    logic [5:0] got;
    logic [5:0] e;
    string      n;
    got = {stepleft, stepright, stepjump, keys_held};
    if (resp_due) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL no_expectation got=%b exp=none", got);
      end else begin
        e = exp_q.pop_front();
        n = tag_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL %s got=%b exp=%b", n, got, e);
        end
      end
    end else if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL leftover_expectations got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic send(input logic [7:0] c, input logic [5:0] e, input string n);
    code_valid = 1'b1;
    code       = c;
    exp_q.push_back(e);
    tag_q.push_back(n);
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic probe_chk(input logic [5:0] e, input string n);
    probe = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(n);
    @(negedge clk);
    probe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; code_valid = 1'b0; code = 8'h00; probe = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    probe_chk(6'b000_000, "reset");

    // Simple press/release of left
    send(8'h1C, 6'b100_001, "l_make");
    send(8'hF0, 6'b100_001, "l_brk_pfx");
    send(8'h1C, 6'b000_000, "l_brk");

    // Left then right: newest wins, releasing it hands back to left
    send(8'h1C, 6'b100_001, "lr_l");
    send(8'h23, 6'b010_011, "lr_r");
    send(8'hF0, 6'b010_011, "lr_pfx");
    send(8'h23, 6'b100_001, "lr_rel_r");
    send(8'hF0, 6'b100_001, "lr_pfx2");
    send(8'h1C, 6'b000_000, "lr_rel_l");

    // Right then left; typematic right must not steal direction
    send(8'h23, 6'b010_010, "rl_r");
    send(8'h1C, 6'b100_011, "rl_l");
    send(8'h23, 6'b100_011, "rl_typ_r");
    send(8'hF0, 6'b100_011, "rl_pfx");
    send(8'h1C, 6'b010_010, "rl_rel_l");
    send(8'hF0, 6'b010_010, "rl_pfx2");
    send(8'h23, 6'b000_000, "rl_rel_r");

    // Jump pulse and typematic suppression
    send(8'h29, 6'b001_100, "j_make");
    probe_chk(6'b000_100, "j_pulse_end");
    send(8'h29, 6'b000_100, "j_typ1");
    send(8'h29, 6'b000_100, "j_typ2");
    send(8'hF0, 6'b000_100, "j_pfx");
    send(8'h29, 6'b000_000, "j_brk");
    send(8'h29, 6'b001_100, "j_make2");
    probe_chk(6'b000_100, "j_pulse2_end");
    send(8'hF0, 6'b000_100, "j_pfx2");
    send(8'h29, 6'b000_000, "j_brk2");

    // Extended prefix consumes letter codes; E1 is dropped
    send(8'hE0, 6'b000_000, "x_pfx");
    send(8'h1C, 6'b000_000, "x_1c_ignored");
    send(8'h1C, 6'b100_001, "x_plain_1c");
    send(8'hE0, 6'b100_001, "xb_pfx");
    send(8'hF0, 6'b100_001, "xb_pfx2");
    send(8'h1C, 6'b100_001, "xb_ignored");
    send(8'hF0, 6'b100_001, "x_pfx3");
    send(8'h1C, 6'b000_000, "x_rel");
    send(8'hE1, 6'b000_000, "e1_drop");
    send(8'h1C, 6'b100_001, "e1_then_1c");
    send(8'h12, 6'b100_001, "unmapped");
    send(8'hF0, 6'b100_001, "e1_pfx");
    send(8'h1C, 6'b000_000, "e1_rel");

`ifdef ARROW_KEYS_EN
    send(8'hE0, 6'b000_000, "a_pfx");
    send(8'h6B, 6'b100_001, "a_left");
    send(8'h1C, 6'b100_001, "a_letter_l");
    send(8'hE0, 6'b100_001, "a_pfx2");
    send(8'hF0, 6'b100_001, "a_pfx3");
    send(8'h6B, 6'b100_001, "a_rel_arrow");
    send(8'hF0, 6'b100_001, "a_pfx4");
    send(8'h1C, 6'b000_000, "a_rel_letter");
    send(8'hE0, 6'b000_000, "a_pfx5");
    send(8'h74, 6'b010_010, "a_right");
    send(8'hE0, 6'b010_010, "a_pfx6");
    send(8'h75, 6'b011_110, "a_jump");
    send(8'hE0, 6'b010_110, "a_pfx7");
    send(8'hF0, 6'b010_110, "a_pfx8");
    send(8'h74, 6'b000_100, "a_rel_right");
    send(8'hE0, 6'b000_100, "a_pfx9");
    send(8'hF0, 6'b000_100, "a_pfx10");
    send(8'h75, 6'b000_000, "a_rel_jump");
`else
    send(8'hE0, 6'b000_000, "na_pfx");
    send(8'h6B, 6'b000_000, "na_6b_ignored");
    send(8'hE0, 6'b000_000, "na_pfx2");
    send(8'h74, 6'b000_000, "na_74_ignored");
`endif

    // Silence timeout: 100 idle cycles after the last byte
    send(8'h23, 6'b010_010, "to_make");
    repeat (98) @(negedge clk);
    probe_chk(6'b010_010, "to_before");
    probe_chk(6'b000_000, "to_expired");

    // Reset in the middle of an extended sequence
    send(8'h23, 6'b010_010, "rs_make");
    send(8'hE0, 6'b010_010, "rs_pfx");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    probe_chk(6'b000_000, "rs_cleared");
    send(8'h1C, 6'b100_001, "rs_unprefixed");

    repeat (3) @(negedge clk);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
